// File: rtl/present_sbox_layer_serial.sv
// Nibble-serial PRESENT S-box layer. A single combinational S-box is shared
// across all nibbles: the state register rotates right by one nibble per
// cycle, substituting the nibble that passes through the low position. After
// NIBBLES rotations every nibble has been substituted once and is back in
// its original position.

module present_sbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    // PRESENT 4-bit S-box lookup
    always_comb begin
        y = 4'h0;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
    end
endmodule

module present_sbox_layer_serial #(
    parameter int NIBBLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_data,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sbox_out;

    present_sbox u_sbox (
        .x (buf_q[3:0]),
        .y (sbox_out)
    );

    // Next-state logic; clear overrides every handshake, buffer is left as-is
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        buf_d   = in_data;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    buf_d = {sbox_out, buf_q[W-1:4]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = DONE;
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, buffer and nibble counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are pure decodes of registered state
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign out_data  = buf_q;

endmodule

// File: tb/tb_present_sbox_layer_serial.sv
// Directed bench for the nibble-serial PRESENT S-box layer.
module tb_present_sbox_layer_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    present_sbox_layer_serial #(.NIBBLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present one state; returns just after the accepting edge
    task automatic accept(input logic [63:0] d);
        int guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid, and cycles with busy high
    task automatic wait_done(output int cyc, output int nbusy);
        cyc = 0;
        nbusy = 0;
        while (!out_valid && cyc < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'h0) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_data=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_zero;
        int cyc, nb;
        accept(64'h0);
        wait_done(cyc, nb);
        n_vec++;
        if (cyc !== 16) begin
            n_err++; $display("FAIL zero_latency: got %0d want 16", cyc);
        end
        n_vec++;
        if (nb !== 16) begin
            n_err++; $display("FAIL zero_busy: got %0d want 16", nb);
        end
        n_vec++;
        if (out_data !== 64'hCCCCCCCCCCCCCCCC || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL zero_data: got %h busy=%b in_ready=%b want cccccccccccccccc 0 0",
                     out_data, busy, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL zero_return: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, nb;
        out_ready = 1'b1;
        accept(64'h0123456789ABCDEF);
        wait_done(cyc, nb);
        n_vec++;
        if (cyc !== 16 || out_data !== 64'hC56B90AD3EF84712) begin
            n_err++; $display("FAIL b2b_first: cyc=%0d data=%h want 16 c56b90ad3ef84712", cyc, out_data);
        end
        // offer the next state already while DONE; it must not be taken yet
        in_valid = 1'b1;
        in_data  = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        accept(64'hFFFFFFFFFFFFFFFF);
        wait_done(cyc, nb);
        n_vec++;
        if (cyc !== 16 || out_data !== 64'h2222222222222222) begin
            n_err++; $display("FAIL b2b_second: cyc=%0d data=%h want 16 2222222222222222", cyc, out_data);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_return: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_backpressure;
        int cyc, nb;
        out_ready = 1'b0;
        accept(64'h0123456789ABCDEF);
        wait_done(cyc, nb);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h1111111111111111 * (i + 2);
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 64'hC56B90AD3EF84712 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: out_valid=%b data=%h in_ready=%b want 1 c56b90ad3ef84712 0",
                         i, out_valid, out_data, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                              in_ready, out_valid, busy);
        end
    endtask

    task automatic test_clear;
        int cyc, nb;
        bit seen;
        accept(64'hDEADBEEFCAFEF00D);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL clear_idle: in_ready=%b busy=%b out_valid=%b want 1 0 0",
                              in_ready, busy, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL clear_no_output: out_valid seen=%b want 0", seen);
        end
        accept(64'h1111111111111111);
        wait_done(cyc, nb);
        n_vec++;
        if (cyc !== 16 || out_data !== 64'h5555555555555555) begin
            n_err++; $display("FAIL clear_resume: cyc=%0d data=%h want 16 5555555555555555", cyc, out_data);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        int cyc, nb;
        accept(64'h0123456789ABCDEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'h0) begin
            n_err++; $display("FAIL rst_run: in_ready=%b out_valid=%b busy=%b data=%h want 1 0 0 0",
                              in_ready, out_valid, busy, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        accept(64'hFFFFFFFFFFFFFFFF);
        wait_done(cyc, nb);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'h0) begin
            n_err++; $display("FAIL rst_done: in_ready=%b out_valid=%b busy=%b data=%h want 1 0 0 0",
                              in_ready, out_valid, busy, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        accept(64'h0);
        wait_done(cyc, nb);
        n_vec++;
        if (cyc !== 16 || out_data !== 64'hCCCCCCCCCCCCCCCC) begin
            n_err++; $display("FAIL rst_resume: cyc=%0d data=%h want 16 cccccccccccccccc", cyc, out_data);
        end
    endtask

    task automatic test_clear_done;
        // block is in DONE from the previous scenario
        clear     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clear     = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL clear_done: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                              in_ready, out_valid, busy);
        end
    endtask

    initial begin
        #1;
        test_reset;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_zero;
        test_back_to_back;
        test_backpressure;
        test_clear;
        test_async_reset;
        test_clear_done;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
